// File: rtl/periph_bus_responder.sv
// Memory-mapped peripheral on the MEM-stage data bus: reload timer with
// interrupt, LED and display-code registers, and a free-running tick counter.
module periph_bus_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h4000_0000,
  parameter logic [31:0] TICK_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemWr,
  input  logic        MemRead,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        irq,
  output logic [7:0]  led,
  output logic [11:0] digi
);

  localparam logic [2:0] W_TH      = 3'd0;
  localparam logic [2:0] W_TL      = 3'd1;
  localparam logic [2:0] W_TCON    = 3'd2;
  localparam logic [2:0] W_LED     = 3'd3;
  localparam logic [2:0] W_DIGI    = 3'd4;
  localparam logic [2:0] W_SYSTICK = 3'd5;

  logic [31:0] th_reg;
  logic [31:0] tl_reg;
  logic        tcon_en;
  logic        tcon_ie;
  logic        tcon_st;
  logic [7:0]  led_reg;
  logic [11:0] digi_reg;
  logic [31:0] systick_reg;

  logic [2:0]  word_sel;
  logic        wr_en;
  logic        overflow;

  assign word_sel = addr[4:2];
  assign hit      = (addr[31:5] == BASE_ADDR[31:5]) && (addr[1:0] == 2'b00)
                    && (word_sel <= W_SYSTICK);
  assign wr_en    = MemWr && hit;
  assign overflow = tcon_en && (tl_reg == 32'hFFFF_FFFF);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_reg <= 32'h0;
    end else if (wr_en && word_sel == W_TH) begin
      th_reg <= wdata;
    end
  end

  // A CPU store to TL beats the timer; a reload uses TH as it stood before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tl_reg <= 32'h0;
    end else if (wr_en && word_sel == W_TL) begin
      tl_reg <= wdata;
    end else if (overflow) begin
      tl_reg <= th_reg;
    end else if (tcon_en) begin
      tl_reg <= tl_reg + 32'd1;
    end
  end

  // The overflow set of ST is ORed into a concurrent TCON store so no interrupt is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcon_en <= 1'b0;
      tcon_ie <= 1'b0;
      tcon_st <= 1'b0;
    end else if (wr_en && word_sel == W_TCON) begin
      tcon_en <= wdata[0];
      tcon_ie <= wdata[1];
      tcon_st <= wdata[2] | (overflow & tcon_ie);
    end else if (overflow && tcon_ie) begin
      tcon_st <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_reg  <= 8'h0;
      digi_reg <= 12'h0;
    end else if (wr_en) begin
      if (word_sel == W_LED)  led_reg  <= wdata[7:0];
      if (word_sel == W_DIGI) digi_reg <= wdata[11:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      systick_reg <= TICK_RESET;
    end else begin
      systick_reg <= systick_reg + 32'd1;
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (MemRead && hit) begin
      case (word_sel)
        W_TH:      rdata = th_reg;
        W_TL:      rdata = tl_reg;
        W_TCON:    rdata = {29'h0, tcon_st, tcon_ie, tcon_en};
        W_LED:     rdata = {24'h0, led_reg};
        W_DIGI:    rdata = {20'h0, digi_reg};
        W_SYSTICK: rdata = systick_reg;
        default:   rdata = 32'h0;
      endcase
    end
  end

  assign irq  = tcon_ie & tcon_st;
  assign led  = led_reg;
  assign digi = digi_reg;

endmodule

// File: tb/tb_periph_bus_responder.sv
// Directed bench for periph_bus_responder: bus stores/loads on the falling
// edge, expected values worked out by hand from the register map.
module tb_periph_bus_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] O_TH = 32'h00, O_TL = 32'h04, O_TCON = 32'h08;
  localparam logic [31:0] O_LED = 32'h0C, O_DIGI = 32'h10, O_TICK = 32'h14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        MemWr = 1'b0;
  logic        MemRead = 1'b0;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;
  logic [7:0]  led;
  logic [11:0] digi;

  int checks = 0;
  int errors = 0;
  logic [31:0] tick_model = 32'h0;

  periph_bus_responder dut (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .MemWr(MemWr),
    .MemRead(MemRead), .rdata(rdata), .hit(hit), .irq(irq), .led(led), .digi(digi)
  );

  always #5 clk = ~clk;

  // Independent cycle count since the last reset, used as the SYSTICK reference.
  always @(posedge clk or posedge reset) begin
    if (reset) tick_model <= 32'h0;
    else       tick_model <= tick_model + 32'd1;
  end

  task automatic read_reg(input logic [31:0] off, output logic [31:0] data);
    addr = BASE + off; MemRead = 1'b1;
    #1 data = rdata;
    MemRead = 1'b0;
  endtask

  task automatic write_reg(input logic [31:0] off, input logic [31:0] data);
    addr = BASE + off; wdata = data; MemWr = 1'b1;
    @(negedge clk);
    MemWr = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    @(negedge clk);
    checks++; if (led !== 8'h0) begin errors++; $display("[TB] FAIL reset_led: got %h, expected 00", led); end
    checks++; if (digi !== 12'h0) begin errors++; $display("[TB] FAIL reset_digi: got %h, expected 000", digi); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b, expected 0", irq); end
    read_reg(O_TCON, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_tcon: got %h, expected 0", v); end
    reset = 1'b0;
    read_reg(O_TICK, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL reset_systick: got %h, expected 0", v); end
  endtask

  task automatic test_led_digi;
    logic [31:0] v;
    write_reg(O_LED, 32'h0000_01A5);
    checks++; if (led !== 8'hA5) begin errors++; $display("[TB] FAIL led_out: got %h, expected a5", led); end
    read_reg(O_LED, v);
    checks++; if (v !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL led_read: got %h, expected 000000a5", v); end
    write_reg(O_DIGI, 32'h0000_F3C7);
    checks++; if (digi !== 12'h3C7) begin errors++; $display("[TB] FAIL digi_out: got %h, expected 3c7", digi); end
    read_reg(O_DIGI, v);
    checks++; if (v !== 32'h0000_03C7) begin errors++; $display("[TB] FAIL digi_read: got %h, expected 000003c7", v); end
    addr = BASE + O_LED; wdata = 32'h3C; MemWr = 1'b1; MemRead = 1'b1;
    #1;
    checks++; if (rdata !== 32'h0000_00A5) begin errors++; $display("[TB] FAIL rw_same_old: got %h, expected 000000a5", rdata); end
    @(negedge clk);
    MemWr = 1'b0; MemRead = 1'b0;
    read_reg(O_LED, v);
    checks++; if (v !== 32'h0000_003C) begin errors++; $display("[TB] FAIL rw_same_new: got %h, expected 0000003c", v); end
  endtask

  task automatic test_timer_overflow;
    logic [31:0] v;
    write_reg(O_TH, 32'hFFFF_FFFD);
    write_reg(O_TL, 32'hFFFF_FFFE);
    write_reg(O_TCON, 32'h3);
    read_reg(O_TL, v);
    checks++; if (v !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL tl_at_enable: got %h, expected fffffffe", v); end
    @(negedge clk);
    read_reg(O_TL, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL tl_plus1: got %h, expected ffffffff", v); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_early: got %b, expected 0", irq); end
    @(negedge clk);
    read_reg(O_TL, v);
    checks++; if (v !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL tl_reload: got %h, expected fffffffd", v); end
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_rise: got %b, expected 1", irq); end
    read_reg(O_TCON, v);
    checks++; if (v !== 32'h7) begin errors++; $display("[TB] FAIL tcon_st_set: got %h, expected 7", v); end
  endtask

  task automatic test_irq_clear;
    logic [31:0] v;
    write_reg(O_TCON, 32'h3);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_clear: got %b, expected 0", irq); end
    @(negedge clk);
    read_reg(O_TL, v);
    checks++; if (v !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL tl_before_ovf2: got %h, expected ffffffff", v); end
    write_reg(O_TCON, 32'h3);
    checks++; if (irq !== 1'b1) begin errors++; $display("[TB] FAIL irq_set_dominates: got %b, expected 1", irq); end
    read_reg(O_TCON, v);
    checks++; if (v !== 32'h7) begin errors++; $display("[TB] FAIL tcon_set_dominates: got %h, expected 7", v); end
    write_reg(O_TCON, 32'h5);
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL irq_ie_clear: got %b, expected 0", irq); end
    write_reg(O_TCON, 32'h0);
  endtask

  task automatic test_tl_write_collision;
    logic [31:0] v;
    write_reg(O_TL, 32'h05);
    write_reg(O_TCON, 32'h1);
    read_reg(O_TL, v);
    checks++; if (v !== 32'h05) begin errors++; $display("[TB] FAIL tl_pre_collision: got %h, expected 5", v); end
    write_reg(O_TL, 32'h10);
    read_reg(O_TL, v);
    checks++; if (v !== 32'h10) begin errors++; $display("[TB] FAIL tl_cpu_wins: got %h, expected 10", v); end
    @(negedge clk);
    read_reg(O_TL, v);
    checks++; if (v !== 32'h11) begin errors++; $display("[TB] FAIL tl_after_cpu: got %h, expected 11", v); end
    addr = BASE + O_TL; MemRead = 1'b0;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL no_read_strobe: got %h, expected 0", rdata); end
    checks++; if (hit !== 1'b1) begin errors++; $display("[TB] FAIL hit_valid: got %b, expected 1", hit); end
  endtask

  task automatic test_reset_mid_count;
    logic [31:0] v;
    @(negedge clk);
    write_reg(O_TL, 32'h1234);
    @(negedge clk);
    read_reg(O_TL, v);
    checks++; if (v !== 32'h1235) begin errors++; $display("[TB] FAIL tl_counting: got %h, expected 1235", v); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (led !== 8'h0) begin errors++; $display("[TB] FAIL midreset_led: got %h, expected 00", led); end
    checks++; if (digi !== 12'h0) begin errors++; $display("[TB] FAIL midreset_digi: got %h, expected 000", digi); end
    checks++; if (irq !== 1'b0) begin errors++; $display("[TB] FAIL midreset_irq: got %b, expected 0", irq); end
    read_reg(O_TL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL midreset_tl: got %h, expected 0", v); end
    read_reg(O_TCON, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL midreset_tcon: got %h, expected 0", v); end
    reset = 1'b0;
    @(negedge clk);
    read_reg(O_TICK, v);
    checks++; if (v !== 32'h1) begin errors++; $display("[TB] FAIL systick_restart: got %h, expected 1", v); end
    read_reg(O_TL, v);
    checks++; if (v !== 32'h0) begin errors++; $display("[TB] FAIL tl_held_after_reset: got %h, expected 0", v); end
  endtask

  task automatic test_decode_systick;
    logic [31:0] v;
    logic [31:0] bad_offs [3];
    bad_offs[0] = 32'h18; bad_offs[1] = 32'h1C; bad_offs[2] = 32'h02;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      addr = BASE + bad_offs[i]; MemRead = 1'b1;
      #1;
      checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL miss_hit_%0d: got %b, expected 0", i, hit); end
      checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL miss_rdata_%0d: got %h, expected 0", i, rdata); end
    end
    addr = 32'h5000_0000;
    #1;
    checks++; if (hit !== 1'b0) begin errors++; $display("[TB] FAIL other_base_hit: got %b, expected 0", hit); end
    MemRead = 1'b0;
    @(negedge clk);
    write_reg(O_LED, 32'h5A);
    write_reg(32'h0E, 32'hFF);
    checks++; if (led !== 8'h5A) begin errors++; $display("[TB] FAIL misaligned_write: got %h, expected 5a", led); end
    write_reg(O_TICK, 32'hDEAD);
    read_reg(O_TICK, v);
    checks++; if (v !== tick_model) begin errors++; $display("[TB] FAIL systick_ro: got %h, expected %h", v, tick_model); end
    @(negedge clk);
    read_reg(O_TICK, v);
    checks++; if (v !== tick_model) begin errors++; $display("[TB] FAIL systick_inc: got %h, expected %h", v, tick_model); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset;
    test_led_digi;
    test_timer_overflow;
    test_irq_clear;
    test_tl_write_collision;
    test_reset_mid_count;
    test_decode_systick;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
